// File: rtl/display_scan_mux_pkg.sv
// Shared constants, types and helpers for the seven-segment scan multiplexer.
// Digit count, anode/decimal-point idle levels and slot index width live here.
package display_scan_mux_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;

  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 4'b1111;
  localparam logic                  DP_OFF     = 1'b1;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // One displayable frame: four nibbles plus their decimal-point requests.
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
  } frame_t;

  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] anode_for(input idx_t idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/display_scan_mux_prescaler.sv
// Slot-rate prescaler: free-running 0..DIV-1 counter with a tick on the last count.
// Count is exported so the parent can place its guard window without a second counter.
module refresh_prescaler
  import display_scan_mux_pkg::*;
#(
  parameter  int CLK_HZ     = 100_000_000,
  parameter  int REFRESH_HZ = 1000,
  localparam int DIV        = CLK_HZ / REFRESH_HZ,
  localparam int CNT_W      = cnt_width(DIV)
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic             Tick,
  output logic [CNT_W-1:0] Count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  assign Tick = (Count == LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Count <= '0;
    end else if (Tick) begin
      Count <= '0;
    end else begin
      Count <= Count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit seven-segment scan multiplexer: frame-synchronous shadow update,
// leading-zero blanking and an all-anodes-off guard at the start of every slot.
module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   DpIn,
  input  logic                    Load,
  input  logic                    BlankLeadZero,
  output logic [3:0]              HexVal,
  output logic                    Dp,
  output logic [NUM_DIGITS-1:0]   An,
  output logic                    FrameStart
);

  localparam int CNT_W = cnt_width(CLK_HZ / REFRESH_HZ);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);

  logic             tick;
  logic [CNT_W-1:0] count;

  idx_t   idx_reg;
  frame_t pending_reg;
  frame_t shadow_reg;
  logic   pend_flag_reg;
  logic   blank_reg;
  logic   wrap_reg;

  frame_t                load_frame;
  logic                  boundary;
  logic                  lit;
  logic [NUM_DIGITS-1:0] dark;

  refresh_prescaler #(
    .CLK_HZ     (CLK_HZ),
    .REFRESH_HZ (REFRESH_HZ)
  ) u_prescaler (
    .Clk   (Clk),
    .Reset (Reset),
    .Tick  (tick),
    .Count (count)
  );

  assign load_frame = {Value, DpIn};
  assign boundary   = tick && (idx_reg == IDX_LAST);

  // A digit goes dark only when it and every digit to its left carry neither a
  // nonzero nibble nor a decimal point; the rightmost digit always shows.
  assign dark[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_dark
    assign dark[gi] = blank_reg
                   && (shadow_reg.value[4*NUM_DIGITS-1:4*gi] == '0)
                   && (shadow_reg.dp[NUM_DIGITS-1:gi] == '0);
  end

  assign lit = (count >= GUARD_END) && !dark[idx_reg];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx_reg       <= '0;
      pending_reg   <= '0;
      shadow_reg    <= '0;
      pend_flag_reg <= 1'b0;
      blank_reg     <= 1'b0;
      wrap_reg      <= 1'b0;
    end else begin
      wrap_reg <= boundary;
      if (tick) begin
        idx_reg   <= idx_reg + IDX_W'(1);
        blank_reg <= BlankLeadZero;
      end
      // Shadow only changes at the 3->0 wrap so a frame is never torn.
      if (boundary) begin
        if (Load) begin
          shadow_reg <= load_frame;
        end else if (pend_flag_reg) begin
          shadow_reg <= pending_reg;
        end
        pend_flag_reg <= 1'b0;
      end else if (Load) begin
        pending_reg   <= load_frame;
        pend_flag_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      HexVal     <= 4'h0;
      Dp         <= DP_OFF;
      An         <= AN_ALL_OFF;
      FrameStart <= 1'b0;
    end else begin
      HexVal     <= shadow_reg.value[{idx_reg, 2'b00} +: 4];
      Dp         <= ~shadow_reg.dp[idx_reg];
      An         <= lit ? anode_for(idx_reg) : AN_ALL_OFF;
      FrameStart <= wrap_reg;
    end
  end

endmodule
